// File: rtl/laser_cannon_pkg.sv
// Shared colour codes, screen geometry and laser FSM encoding for the
// ship / alien / laser / colour-mux blocks.
package laser_cannon_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int V_OFFSET      = 10;
    localparam int SHIP_HEIGHT   = 30;

    typedef enum logic [2:0] {
        BACKGROUND = 3'd0,
        SPACESHIP  = 3'd1,
        ALIENS0    = 3'd2,
        ALIENS1    = 3'd3,
        ALIENS2    = 3'd4,
        ALIENS3    = 3'd5,
        LASER      = 3'd6,
        NONE       = 3'd7
    } color_t;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLYING   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

endpackage

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector; rise is high while d=1 and the
// previous-cycle sample of d was 0.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev;

    // NOTE: reset is synchronous and active-high to match the rest of the codebase.
    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/laser_cannon.sv
// Single-shot laser cannon: launches from the gun muzzle, climbs one STEP per
// tick, retires on hit or at the far edge, and paints its pixels as LASER.
module laser_cannon
    import laser_cannon_pkg::*;
#(
    parameter int STEP           = 8,
    parameter int LASER_WIDTH    = 4,
    parameter int LASER_HEIGHT   = 12,
    parameter int COOLDOWN_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       fire,
    input  logic [9:0] gunPosition,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    input  logic       hit,
    output logic       active,
    output logic [9:0] laserX,
    output logic [9:0] laserY,
    output logic [2:0] color
);

    localparam logic [10:0]        LAUNCH_Y = 11'(V_OFFSET + SHIP_HEIGHT);
    localparam logic [10:0]        Y_LIMIT  = 11'(SCREEN_HEIGHT - V_OFFSET - LASER_HEIGHT);
    localparam logic [10:0]        STEP_W   = 11'(STEP);
    localparam logic [2:0]         CNT_LAST = 3'(COOLDOWN_TICKS);
    localparam logic signed [10:0] HALF_W   = 11'(LASER_WIDTH / 2);
    localparam logic signed [10:0] BEAM_H   = 11'(LASER_HEIGHT);

    logic [1:0]  state, state_d;
    logic [2:0]  count, count_d;
    logic        active_d;
    logic [9:0]  x_d, y_d;
    logic [10:0] y_step;
    logic        fire_rise;
    logic        on_laser;

    rise_detect u_fire_edge (
        .clk   (clk),
        .reset (reset),
        .d     (fire),
        .rise  (fire_rise)
    );

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state;
        count_d  = count;
        active_d = active;
        x_d      = laserX;
        y_d      = laserY;
        y_step   = {1'b0, laserY} + STEP_W;
        case (state)
            ST_IDLE: begin
                if (fire_rise) begin
                    x_d      = gunPosition;
                    y_d      = LAUNCH_Y[9:0];
                    active_d = 1'b1;
                    state_d  = ST_FLYING;
                end
            end
            ST_FLYING: begin
                if (hit) begin
                    active_d = 1'b0;
                    count_d  = 3'd0;
                    state_d  = ST_COOLDOWN;
                end else if (tick) begin
                    if (y_step > Y_LIMIT) begin
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        y_d = y_step[9:0];
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    count_d = count + 3'd1;
                    if (count_d == CNT_LAST) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pixel test uses next-state position so a retiring shot is never drawn.
    logic signed [10:0] h_s, v_s, x_s, y_s;
    assign h_s = signed'({1'b0, hPos});
    assign v_s = signed'({1'b0, vPos});
    assign x_s = signed'({1'b0, x_d});
    assign y_s = signed'({1'b0, y_d});

    assign on_laser = active_d
                   && (h_s >= x_s - HALF_W) && (h_s < x_s + HALF_W)
                   && (v_s >= y_s)          && (v_s < y_s + BEAM_H);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= 3'd0;
            active <= 1'b0;
            laserX <= 10'd0;
            laserY <= 10'd0;
            color  <= NONE;
        end else begin
            state  <= state_d;
            count  <= count_d;
            active <= active_d;
            laserX <= x_d;
            laserY <= y_d;
            color  <= on_laser ? LASER : NONE;
        end
    end

endmodule

// File: tb/tb_laser_cannon.sv
// Directed, table-driven bench for laser_cannon: launch, pixel scan, flight,
// miss, hit/cooldown, fire-hold and mid-flight reset.
module tb_laser_cannon;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] gunPosition = 10'd0;
    logic [9:0] hPos = 10'd0;
    logic [9:0] vPos = 10'd0;
    logic       hit = 1'b0;
    logic       active;
    logic [9:0] laserX, laserY;
    logic [2:0] color;

    localparam int C_LASER = 6;
    localparam int C_NONE  = 7;

    int n_checks = 0;
    int n_fail   = 0;

    laser_cannon dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .fire        (fire),
        .gunPosition (gunPosition),
        .hPos        (hPos),
        .vPos        (vPos),
        .hit         (hit),
        .active      (active),
        .laserX      (laserX),
        .laserY      (laserY),
        .color       (color)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        int h;
        int v;
        int exp_color;
    } pix_vec_t;

    pix_vec_t scan[$];

    initial begin
        // Beam at x=320, y=40: columns 318..321, rows 40..51.
        for (int h = 316; h <= 323; h++)
            scan.push_back('{h, 45, (h >= 318 && h <= 321) ? C_LASER : C_NONE});
        for (int h = 316; h <= 323; h++)
            scan.push_back('{h, 52, C_NONE});
        scan.push_back('{320, 40, C_LASER});
        scan.push_back('{320, 39, C_NONE});
        scan.push_back('{321, 51, C_LASER});
        scan.push_back('{322, 51, C_NONE});

        // Reset state
        step(); step();
        check("reset_active", int'(active), 0);
        check("reset_x", int'(laserX), 0);
        check("reset_y", int'(laserY), 0);
        check("reset_color", int'(color), C_NONE);
        reset = 1'b0;
        step();
        check("idle_color", int'(color), C_NONE);

        // Launch at 320
        gunPosition = 10'd320;
        fire = 1'b1;
        step();
        check("launch_active", int'(active), 1);
        check("launch_x", int'(laserX), 320);
        check("launch_y", int'(laserY), 40);
        fire = 1'b0;
        step();

        // Pixel scan, one cycle latency
        foreach (scan[i]) begin
            hPos = 10'(scan[i].h);
            vPos = 10'(scan[i].v);
            step();
            check($sformatf("scan_h%0d_v%0d", scan[i].h, scan[i].v), int'(color), scan[i].exp_color);
        end

        // Fire edge while flying is discarded, no steering
        gunPosition = 10'd500;
        fire = 1'b1;
        step();
        fire = 1'b0;
        step();
        check("fly_refire_x", int'(laserX), 320);
        check("fly_refire_y", int'(laserY), 40);

        // 52 ticks to the top, 53rd misses
        hPos = 10'd320;
        vPos = 10'd456;
        tick = 1'b1;
        for (int i = 0; i < 52; i++) step();
        check("top_y", int'(laserY), 456);
        check("top_active", int'(active), 1);
        check("top_color", int'(color), C_LASER);
        step();
        tick = 1'b0;
        check("miss_active", int'(active), 0);
        check("miss_color", int'(color), C_NONE);
        check("miss_y_hold", int'(laserY), 456);

        // Relaunch, fly to 104, hit with simultaneous tick
        gunPosition = 10'd100;
        fire = 1'b1;
        step();
        fire = 1'b0;
        check("relaunch_x", int'(laserX), 100);
        tick = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("pre_hit_y", int'(laserY), 104);
        hit = 1'b1;
        step();
        hit = 1'b0;
        tick = 1'b0;
        check("hit_y", int'(laserY), 104);
        check("hit_active", int'(active), 0);

        // Cooldown: fire edges after ticks 1..3 ignored
        gunPosition = 10'd200;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            fire = 1'b1;
            step();
            check($sformatf("cooldown_fire_%0d", i + 1), int'(active), 0);
            fire = 1'b0;
            step();
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("cooldown_done_active", int'(active), 0);
        fire = 1'b1;
        step();
        check("rearm_active", int'(active), 1);
        check("rearm_y", int'(laserY), 40);
        check("rearm_x", int'(laserX), 200);

        // Hold fire through a miss: no auto-repeat
        tick = 1'b1;
        for (int i = 0; i < 200; i++) step();
        tick = 1'b0;
        check("hold_active", int'(active), 0);
        check("hold_y", int'(laserY), 456);
        fire = 1'b0;
        step();
        check("release_active", int'(active), 0);
        fire = 1'b1;
        step();
        fire = 1'b0;
        check("repress_active", int'(active), 1);
        check("repress_y", int'(laserY), 40);

        // Mid-flight reset at y=200 with a coincident hit
        hPos = 10'd200;
        vPos = 10'd205;
        tick = 1'b1;
        for (int i = 0; i < 20; i++) step();
        tick = 1'b0;
        check("preflight_y", int'(laserY), 200);
        check("preflight_color", int'(color), C_LASER);
        reset = 1'b1;
        hit = 1'b1;
        step();
        reset = 1'b0;
        hit = 1'b0;
        check("midreset_active", int'(active), 0);
        check("midreset_y", int'(laserY), 0);
        check("midreset_x", int'(laserX), 0);
        check("midreset_color", int'(color), C_NONE);

        // Hit in IDLE is ignored: a fire edge still launches at once
        hit = 1'b1;
        step();
        hit = 1'b0;
        fire = 1'b1;
        step();
        fire = 1'b0;
        check("idle_hit_launch", int'(active), 1);
        check("idle_hit_y", int'(laserY), 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/laser_cannon.md
Name: laser_cannon

Overview:
- Consumes the ship's `gunPosition` and the player fire button.
- Launches one laser shot from the gun muzzle and advances it away from the ship once per movement tick.
- Retires the shot on a hit report from the alien block, or when it reaches the far screen edge.
- Per pixel, drives a registered colour code (LASER or NONE) into the same colour-priority mux as the ship and aliens.

Parameters:
- SCREEN_WIDTH, 640, visible columns
- SCREEN_HEIGHT, 480, visible rows
- SHIP_HEIGHT, 30, ship sprite height in rows
- V_OFFSET, 10, row margin at both ship edge and far edge
- STEP, 8, rows advanced per tick
- LASER_WIDTH, 4, beam width in columns (even)
- LASER_HEIGHT, 12, beam length in rows
- COOLDOWN_TICKS, 4, ticks after a hit before re-arming

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle movement strobe, once per frame
- fire  in  1  fire button, level, synchronised upstream
- gunPosition  in  10  ship centre column
- hPos  in  10  current pixel column
- vPos  in  10  current pixel row
- hit  in  1  one-cycle pulse from alien block: laser collided
- active  out  1  shot in flight
- laserX  out  10  beam centre column
- laserY  out  10  beam leading row (ship-side edge of beam)
- color  out  3  LASER (6) or NONE (7)

Behaviour:
- Reset values: state IDLE, `active`=0, `laserX`=0, `laserY`=0, `color`=NONE, cooldown count 0, fire history 0.
- Reset has priority over every other event, including mid-flight and mid-cooldown.
- Fire detection: a rising edge of `fire` is `fire`=1 while the registered previous `fire`=0. Holding the button never auto-repeats.
- States: IDLE, FLYING, COOLDOWN.
- IDLE, on a fire edge:
  - `laserX` <= `gunPosition`
  - `laserY` <= V_OFFSET+SHIP_HEIGHT (40)
  - `active` <= 1
  - next state FLYING
  - Launch is independent of `tick`.
- FLYING, priority `hit` > `tick`:
  - `hit`=1: `active` <= 0, count <= 0, go to COOLDOWN. A `tick` in the same cycle is ignored.
  - `tick`=1 and `laserY`+STEP > SCREEN_HEIGHT-V_OFFSET-LASER_HEIGHT (458): `active` <= 0, go to IDLE (miss).
  - `tick`=1 otherwise: `laserY` <= `laserY`+STEP.
  - Compare in 11 bits so there is no wrap.
  - Maximum `laserY` reached is 456.
- COOLDOWN: each `tick` increments count. The tick that brings count to COOLDOWN_TICKS returns to IDLE.
- Fire edges in FLYING or COOLDOWN are discarded, not queued.
- `hit` outside FLYING is ignored.
- `laserX` is latched at launch; later ship movement does not steer the shot.
- `laserX` and `laserY` hold their last values after retirement.
- Colour, registered, 1-cycle latency from `hPos`/`vPos`:
  - LASER when `active`=1 and `laserX`-LASER_WIDTH/2 <= `hPos` < `laserX`+LASER_WIDTH/2 and `laserY` <= `vPos` < `laserY`+LASER_HEIGHT.
  - NONE otherwise.
  - Compute bounds in 11-bit signed arithmetic so `laserX`<2 does not underflow.
- `active` and `color` update in the same cycle as the state change. A just-retired shot is never drawn on the following cycle.

Decomposition:
- Shared package holds:
  - colour codes BACKGROUND=0, SPACESHIP=1, ALIENS0..3=2..5, LASER=6, NONE=7
  - SCREEN_WIDTH, SCREEN_HEIGHT, V_OFFSET, SHIP_HEIGHT
  - the laser state encoding
- Those colour codes and screen constants are shared with the ship, alien and colour-mux blocks.
- One natural sub-module: `rise_detect` (1-bit registered edge detector), reused for the left/right buttons later.
- The FSM, position registers and pixel compare stay in `laser_cannon`.

Test Plan:
- Reset, then `fire` edge with `gunPosition`=320 → next cycle `active`=1, `laserX`=320, `laserY`=40, state FLYING.
- Launch at 320, no ticks, scan `hPos` 316..323 on `vPos`=45 → `color`=LASER exactly for `hPos` 318..321, one cycle late. `vPos`=52 → NONE everywhere.
- Launch then 52 ticks → `laserY`=456, `active`=1. 53rd tick → `active`=0, state IDLE, `color`=NONE.
- `hit` and `tick` in the same cycle at `laserY`=104 → `laserY` stays 104, `active`=0, state COOLDOWN. Fire edges during the next 3 ticks are ignored. After the 4th tick a fire edge relaunches at `laserY`=40.
- Hold `fire` high for 200 cycles, then a miss → no relaunch until `fire` drops and rises again. `fire` edge while FLYING → `laserX` unchanged even if `gunPosition` moves to 500.
- Assert `reset` mid-flight at `laserY`=200 → next cycle `active`=0, `laserY`=0, `color`=NONE. A `hit` pulse in the same cycle has no effect.
